// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the fifo read-side stream adapter.
// Optional statistics counters are enabled with FIFO_STREAM_READER_COUNT_EN.
package fifo_stream_pkg;

   localparam int READER_BUF_DEPTH = 2;
   localparam int STAT_W           = 16;

   typedef logic [1:0] cnt_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Fifo out-port and downstream valid/ready stream bundle.
// master = reader side, slave = fifo plus downstream consumer.
interface fifo_stream_reader_if #(
   parameter int WIDTH = 16
);

   logic             fifo_pop;
   logic             fifo_nempty;
   logic [WIDTH-1:0] fifo_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (
      output fifo_pop,
      output m_valid,
      output m_data,
      input  fifo_nempty,
      input  fifo_data,
      input  m_ready
   );

   modport slave (
      input  fifo_pop,
      input  m_valid,
      input  m_data,
      output fifo_nempty,
      output fifo_data,
      output m_ready
   );

endinterface

// File: rtl/fifo_stream_reader_stream_buf2.sv
// Two-entry register fifo holding prefetched words.
// clear_i wins over push/pop in the same cycle.
module stream_buf2
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_data_o,
   output cnt_t             count_o
);

   logic [READER_BUF_DEPTH-1:0][WIDTH-1:0] mem_q;
   logic head_q, head_d;
   logic tail_q, tail_d;
   cnt_t count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear_i) begin
         head_d  = 1'b0;
         tail_d  = 1'b0;
         count_d = '0;
      end else begin
         if (push_i)
            tail_d = ~tail_q;
         if (pop_i)
            head_d = ~head_q;
         count_d = count_q + cnt_t'(push_i)
                 - cnt_t'(pop_i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q   <= '0;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (push_i && !clear_i)
            mem_q[tail_q] <= push_data_i;
      end
   end

   assign head_data_o = mem_q[head_q];
   assign count_o     = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Fifo read-side consumer: hides the one-cycle read latency behind a
// 2-entry prefetch. Define FIFO_STREAM_READER_COUNT_EN for statistics.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int BUF_DEPTH = READER_BUF_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   output logic              busy,
`ifdef FIFO_STREAM_READER_COUNT_EN
   output logic [STAT_W-1:0] word_count,
   output logic [STAT_W-1:0] stall_count,
`endif
   fifo_stream_reader_if.master bus
);

   if (BUF_DEPTH != READER_BUF_DEPTH) begin : g_bad_depth
      $error("fifo_stream_reader: BUF_DEPTH must be 2");
   end

   logic             inflight_q, inflight_d;
   logic             discard_q, discard_d;
   logic             out_accept;
   logic             push;
   logic             pop_ok;
   logic [2:0]       occ;
   cnt_t             count;
   logic [WIDTH-1:0] head;

   // occ is the occupancy left after this edge's accept; keep it below 2
   always_comb begin
      out_accept = (count != '0) && bus.m_ready;
      occ        = 3'(count) + 3'(inflight_q)
                 - 3'(out_accept);
      pop_ok     = !reset && !flush
                && bus.fifo_nempty && (occ < 3'd2);
      push       = inflight_q && !discard_q && !flush;
      inflight_d = pop_ok;
      discard_d  = flush;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inflight_q <= 1'b0;
         discard_q  <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   stream_buf2 #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk_i       (clock),
      .rst_i       (reset),
      .clear_i     (flush),
      .push_i      (push),
      .push_data_i (bus.fifo_data),
      .pop_i       (out_accept),
      .head_data_o (head),
      .count_o     (count)
   );

   assign bus.fifo_pop = pop_ok;
   assign bus.m_valid  = (count != '0);
   assign bus.m_data   = head;
   assign busy         = (count != '0) || inflight_q;

`ifdef FIFO_STREAM_READER_COUNT_EN
   logic [STAT_W-1:0] word_q, word_d;
   logic [STAT_W-1:0] stall_q, stall_d;

   // word counter wraps, stall counter saturates; flush touches neither
   always_comb begin
      word_d  = word_q;
      stall_d = stall_q;
      if (out_accept && !flush)
         word_d = word_q + STAT_W'(1);
      if ((count != '0) && !bus.m_ready
          && (stall_q != '1))
         stall_d = stall_q + STAT_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         word_q  <= '0;
         stall_q <= '0;
      end else begin
         word_q  <= word_d;
         stall_q <= stall_d;
      end
   end

   assign word_count  = word_q;
   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader with a behavioural fifo,
// a cycle reference model and an in-order scoreboard.
module tb_fifo_stream_reader;

   localparam int W = 16;

   logic clock = 1'b0;
   logic reset;
   logic flush;
   logic busy;

   fifo_stream_reader_if #(.WIDTH(W)) bus ();

`ifdef FIFO_STREAM_READER_COUNT_EN
   logic [15:0] word_count;
   logic [15:0] stall_count;
`endif

   fifo_stream_reader #(
      .WIDTH     (W),
      .BUF_DEPTH (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .busy        (busy),
`ifdef FIFO_STREAM_READER_COUNT_EN
      .word_count  (word_count),
      .stall_count (stall_count),
`endif
      .bus         (bus)
   );

   always #5 clock = ~clock;

   logic [W-1:0] fq[$];
   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   int pops  = 0;
   int m_cnt = 0;
   int m_inf = 0;
   logic pat [6] = '{1'b1, 1'b0, 1'b0,
                     1'b1, 1'b0, 1'b1};

   typedef struct packed {
      logic       rdy;
      logic       pop;
      logic       vld;
      logic [15:0] dat;
      logic       bsy;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm,
                      input logic [15:0] act,
                      input logic [15:0] ex);
      n_vec++;
      if (act !== ex) begin
         n_err++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, ex);
      end
   endtask

   // fifo model: registered read data, nempty updated after each edge
   always @(posedge clock) begin
      if (bus.fifo_pop && bus.fifo_nempty)
         bus.fifo_data <= fq.pop_front();
      bus.fifo_nempty <= (fq.size() != 0);
   end

   // reference occupancy model and scoreboard, sampled mid-cycle
   always @(negedge clock) begin
      logic acc_raw, acc, px, pa;
      logic [W-1:0] e;
      if (reset) begin
         m_cnt = 0;
         m_inf = 0;
      end else begin
         acc_raw = (m_cnt != 0) && bus.m_ready;
         acc     = acc_raw && !flush;
         px = bus.fifo_nempty && !flush
           && ((m_cnt + m_inf - int'(acc_raw)) < 2);
         pa = bus.fifo_pop && bus.fifo_nempty;
         chk("m_valid", 16'(bus.m_valid),
             16'(m_cnt != 0));
         chk("busy", 16'(busy),
             16'(m_cnt != 0 || m_inf != 0));
         chk("fifo_pop", 16'(bus.fifo_pop), 16'(px));
         chk("occupancy<=2",
             16'((m_cnt + m_inf) <= 2), 16'd1);
         if (acc) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL scoreboard: got %h expected none",
                        bus.m_data);
            end else begin
               e = exp_q.pop_front();
               chk("m_data order", bus.m_data, e);
            end
         end
         if (pa)
            pops++;
         if (flush) begin
            m_cnt = 0;
            m_inf = 0;
         end else begin
            m_cnt = m_cnt + m_inf - int'(acc);
            m_inf = int'(pa);
         end
      end
   end

   task automatic preload(input logic [15:0] base,
                          input int n);
      for (int i = 0; i < n; i++) begin
         fq.push_back(16'(base + 16'(i)));
         exp_q.push_back(16'(base + 16'(i)));
      end
   endtask

   task automatic drop(input int n);
      logic [W-1:0] d;
      for (int i = 0; i < n; i++)
         d = exp_q.pop_front();
   endtask

   task automatic drain(input string nm,
                        input int bound,
                        input bit rnd);
      int k;
      int ofs;
      k   = 0;
      ofs = int'($urandom_range(5, 0));
      while ((exp_q.size() != 0 || busy)
             && k < bound) begin
         if (rnd)
            bus.m_ready = pat[(k + ofs) % 6];
         @(posedge clock);
         #1;
         k++;
      end
      bus.m_ready = 1'b1;
      n_vec++;
      if (exp_q.size() != 0 || busy) begin
         n_err++;
         $display("FAIL %s drain: got %0d left busy=%b expected 0",
                  nm, exp_q.size(), busy);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 16'h1, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 16'h2, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 16'h3, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 16'h4, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 16'h5, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 16'h6, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'h7, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'h8, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b0};

      reset       = 1'b1;
      flush       = 1'b0;
      bus.m_ready = 1'b0;
      step(2);
      chk("rst fifo_pop", 16'(bus.fifo_pop), 16'd0);
      chk("rst m_valid", 16'(bus.m_valid), 16'd0);
      chk("rst m_data", bus.m_data, 16'd0);
      chk("rst busy", 16'(busy), 16'd0);
      reset = 1'b0;
      step(1);

      // streaming at full rate, cycle by cycle
      bus.m_ready = 1'b1;
      preload(16'h0001, 8);
      step(1);
      for (int i = 0; i < 11; i++) begin
         bus.m_ready = tbl[i].rdy;
         @(negedge clock);
         chk($sformatf("t1[%0d] pop", i),
             16'(bus.fifo_pop), 16'(tbl[i].pop));
         chk($sformatf("t1[%0d] valid", i),
             16'(bus.m_valid), 16'(tbl[i].vld));
         chk($sformatf("t1[%0d] busy", i),
             16'(busy), 16'(tbl[i].bsy));
         if (tbl[i].vld)
            chk($sformatf("t1[%0d] data", i),
                bus.m_data, tbl[i].dat);
         step(1);
      end

      // backpressure: exactly two pops, head held stable
      bus.m_ready = 1'b0;
      preload(16'h0001, 8);
      step(1);
      p0 = pops;
      step(2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("t2 valid held", 16'(bus.m_valid), 16'd1);
         chk("t2 data held", bus.m_data, 16'h0001);
         step(1);
      end
      chk("t2 pop count", 16'(pops - p0), 16'd2);
      bus.m_ready = 1'b1;
      drain("t2", 40, 1'b0);

      // toggling ready over 32 words
      preload(16'h0100, 32);
      drain("t3", 400, 1'b1);

      // flush in the capture cycle with one word buffered
      bus.m_ready = 1'b0;
      preload(16'h0A01, 3);
      step(3);
      flush = 1'b1;
      @(negedge clock);
      chk("t4 pop in flush", 16'(bus.fifo_pop), 16'd0);
      step(1);
      flush = 1'b0;
      @(negedge clock);
      chk("t4 valid", 16'(bus.m_valid), 16'd0);
      chk("t4 busy", 16'(busy), 16'd0);
      drop(2);
      bus.m_ready = 1'b1;
      drain("t4", 20, 1'b0);

      // async reset mid-transfer; popped words are lost
      bus.m_ready = 1'b0;
      preload(16'h0D01, 4);
      step(3);
      #1;
      reset = 1'b1;
      #1;
      chk("t5 pop", 16'(bus.fifo_pop), 16'd0);
      chk("t5 valid", 16'(bus.m_valid), 16'd0);
      chk("t5 data", bus.m_data, 16'd0);
      chk("t5 busy", 16'(busy), 16'd0);
      step(1);
      reset = 1'b0;
      drop(2);
      bus.m_ready = 1'b1;
      drain("t5", 20, 1'b0);

`ifdef FIFO_STREAM_READER_COUNT_EN
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("t6 words rst", word_count, 16'd0);
      chk("t6 stalls rst", stall_count, 16'd0);
      bus.m_ready = 1'b1;
      preload(16'h0C01, 5);
      step(1);
      for (int i = 0; i < 6; i++) begin
         bus.m_ready = (i < 3);
         step(1);
      end
      bus.m_ready = 1'b1;
      drain("t6", 20, 1'b0);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      chk("t6 word_count", word_count, 16'd5);
      chk("t6 stall_count", stall_count, 16'd3);
      reset = 1'b1;
      #1;
      chk("t6 words clr", word_count, 16'd0);
      chk("t6 stalls clr", stall_count, 16'd0);
      step(1);
      reset = 1'b0;
`endif

      step(2);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
